// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, FSM states and op-decode helpers for the HI/LO multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the ID/EX stage and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             HiWrite;
  logic             LoWrite;
  logic [WIDTH-1:0] WrData;
  logic             Flush;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Start, Op, A, B, HiWrite, LoWrite, WrData, Flush,
    input  Hi, Lo, Busy, Done, DivByZero
  );

  modport slave (
    input  Start, Op, A, B, HiWrite, LoWrite, WrData, Flush,
    output Hi, Lo, Busy, Done, DivByZero
  );
endinterface

// File: rtl/mult_div_unit_iter_core.sv
// One radix-2 step on the 2*WIDTH work register: shift-add for multiply,
// restoring shift-subtract for divide. Work layout: {upper half, lower half};
// multiply keeps the multiplier in the lower half, divide keeps dividend/quotient there.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] work,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] work_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] top;
  logic [WIDTH:0] diff;

  // Partial remainder is always below the divisor, so the shifted value fits
  // in WIDTH+1 bits and the subtraction's top bit is a clean borrow flag.
  always_comb begin
    sum       = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    top       = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    diff      = top - {1'b0, opnd};
    work_next = '0;
    if (is_div) begin
      if (!diff[WIDTH])
        work_next = {diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
      else
        work_next = {top[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
    end else begin
      work_next = {sum, work[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO; one bit per cycle on
// magnitudes, sign correction applied when the result is committed.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            Clk,
  input logic            Reset,
  mult_div_unit_if.slave bus
);

  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  md_state_e          state;
  md_op_e             op_q;
  logic               sign_a;
  logic               sign_b;
  logic               dz;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] work;
  logic [2*WIDTH-1:0] work_next;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               busy;
  logic               done;
  logic               dbz;

  md_op_e             op_in;
  logic               in_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quo;
  logic [WIDTH-1:0]   fix_rem;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div    (op_is_div(op_q)),
    .work      (work),
    .opnd      (opnd),
    .work_next (work_next)
  );

  // Operand magnitudes for the op being launched this cycle.
  always_comb begin
    op_in     = md_op_e'(bus.Op);
    in_signed = op_is_signed(op_in);
    abs_a     = (in_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    abs_b     = (in_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  end

  // Sign correction of the finished magnitude result; flags are 0 for unsigned ops.
  always_comb begin
    fix_prod = (sign_a ^ sign_b) ? -work : work;
    fix_quo  = (sign_a ^ sign_b) ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    fix_rem  = sign_a ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
  end

  // Control FSM, iteration counter, work registers and the architectural HI/LO.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      op_q     <= MD_MULT;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      dz       <= 1'b0;
      cnt      <= '0;
      work     <= '0;
      opnd     <= '0;
      dividend <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      done <= 1'b0;
      dbz  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            if (!bus.Flush) begin
              op_q     <= op_in;
              sign_a   <= in_signed & bus.A[WIDTH-1];
              sign_b   <= in_signed & bus.B[WIDTH-1];
              work     <= {{WIDTH{1'b0}}, abs_a};
              opnd     <= abs_b;
              dividend <= bus.A;
              cnt      <= '0;
              busy     <= 1'b1;
              if (op_is_div(op_in) && (bus.B == '0)) begin
                dz    <= 1'b1;
                state <= FIN;
              end else begin
                dz    <= 1'b0;
                state <= CALC;
              end
            end
          end else begin
            if (bus.HiWrite) hi <= bus.WrData;
            if (bus.LoWrite) lo <= bus.WrData;
          end
        end
        CALC: begin
          if (bus.Flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            work <= work_next;
            cnt  <= cnt + 6'd1;
            if (cnt == CNT_LAST) state <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!bus.Flush) begin
            done <= 1'b1;
            if (dz) begin
              hi  <= dividend;
              lo  <= '1;
              dbz <= 1'b1;
            end else if (op_is_div(op_q)) begin
              hi <= fix_rem;
              lo <= fix_quo;
            end else begin
              {hi, lo} <= fix_prod;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Hi        = hi;
  assign bus.Lo        = lo;
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.DivByZero = dbz;

endmodule
